// File: rtl/commit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | commit_pkg                                                               |
// | Shared sizing constants, index/count types and ring arithmetic for the   |
// | commit-slot allocator.                                                   |
// | Contents: COMMIT_N/COMMIT_LN/COMMIT_NDEC default geometry, MAX_ALLOC,    |
// |           commit_idx_t (slot index), commit_cnt_t (0..N count),          |
// |           ring_dist() forward distance on the commit ring.               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package commit_pkg;

  localparam int COMMIT_N    = 32;
  localparam int COMMIT_LN   = 5;
  localparam int COMMIT_NDEC = 4;
  localparam int MAX_ALLOC   = 2 * COMMIT_NDEC;

  typedef logic [COMMIT_LN-1:0] commit_idx_t;
  typedef logic [COMMIT_LN:0]   commit_cnt_t;

  // Forward distance from slot a to slot b on a ring of 2**ln entries.
  function automatic int unsigned ring_dist(input int unsigned a,
                                            input int unsigned b,
                                            input int          ln);
    return (b - a) & ((32'd1 << ln) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_mask.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ring_mask                                                                |
// | Contiguous, wrap-aware bit mask on the commit ring: bit i is set when    |
// | slot i lies within count slots forward of start (start inclusive).       |
// | Ports: start [LNCOMMIT-1:0]  first slot of the run                       |
// |        count [LNCOMMIT:0]    run length, 0..NCOMMIT (NCOMMIT = all ones) |
// |        mask  [NCOMMIT-1:0]   resulting slot mask                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ring_mask #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5
) (
  input  logic [LNCOMMIT-1:0] start,
  input  logic [LNCOMMIT:0]   count,
  output logic [NCOMMIT-1:0]  mask
);

  // Each slot measures its own forward offset from start; the modulo wrap of
  // the subtraction makes runs that cross slot NCOMMIT-1 -> 0 come out right.
  for (genvar i = 0; i < NCOMMIT; i++) begin : g_bit
    logic [LNCOMMIT-1:0] w_off;
    assign w_off   = LNCOMMIT'(i) - start;
    assign mask[i] = ({1'b0, w_off} < count);
  end

endmodule
`default_nettype wire

// File: rtl/commit_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | commit_alloc                                                             |
// | Commit-slot allocator feeding rename. Owns the circular window of        |
// | NCOMMIT commit stations (head = oldest live, tail = next free), applies  |
// | per-cycle allocation and retirement, truncates on mispredict and         |
// | empties on trap. All outputs are registers or trivial decodes of them.   |
// | Ports:                                                                   |
// |   clk, reset         clock, synchronous active-high reset                |
// |   alloc_count        slots renamed this cycle                            |
// |   retire_count       oldest slots retired this cycle                     |
// |   trunc_enable/addr  keep head..trunc_addr, free the rest                |
// |   kill_all           free every slot                                     |
// |   next_start         tail (rename instance k uses next_start+k)          |
// |   current_start/end  head / last live slot (end undefined when empty)    |
// |   current_available  free slots                                          |
// |   slot_valid         per-station live bits                               |
// |   empty/full         window occupancy flags                              |
// |   alloc_err          sticky over-allocate / over-retire / bad truncate   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module commit_alloc
  import commit_pkg::*;
#(
  parameter int NCOMMIT  = COMMIT_N,
  parameter int LNCOMMIT = COMMIT_LN,
  parameter int NDEC     = COMMIT_NDEC,
  parameter int HART     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LNCOMMIT-1:0] alloc_count,
  input  logic [LNCOMMIT:0]   retire_count,
  input  logic                trunc_enable,
  input  logic [LNCOMMIT-1:0] trunc_addr,
  input  logic                kill_all,
  output logic [LNCOMMIT-1:0] next_start,
  output logic [LNCOMMIT-1:0] current_start,
  output logic [LNCOMMIT-1:0] current_end,
  output logic [LNCOMMIT:0]   current_available,
  output logic [NCOMMIT-1:0]  slot_valid,
  output logic                empty,
  output logic                full,
  output logic                alloc_err
);

  localparam logic [LNCOMMIT:0]   FULL_CNT = (LNCOMMIT+1)'(NCOMMIT);
  localparam logic [LNCOMMIT-1:0] IDX_ONE  = LNCOMMIT'(1);

  // Geometry sanity checks, evaluated at elaboration only.
  if (NCOMMIT != (1 << LNCOMMIT)) begin : g_chk_size
    $error("commit_alloc: NCOMMIT must equal 2**LNCOMMIT");
  end
  if (2 * NDEC > NCOMMIT) begin : g_chk_ndec
    $error("commit_alloc: 2*NDEC allocations per cycle exceed the window");
  end
  if (HART < 0) begin : g_chk_hart
    $error("commit_alloc: HART must be non-negative");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [LNCOMMIT-1:0] r_head;
  logic [LNCOMMIT-1:0] r_tail;
  logic [LNCOMMIT:0]   r_busy;
  logic [NCOMMIT-1:0]  r_slot_valid;
  logic                r_alloc_err;

  // --------------------------------------------------------------------------
  // Next-state terms
  // --------------------------------------------------------------------------
  logic [LNCOMMIT:0]   w_avail;
  logic                w_over_alloc;
  logic                w_over_retire;
  logic [LNCOMMIT-1:0] w_alloc_eff;
  logic [LNCOMMIT:0]   w_retire_eff;
  logic [LNCOMMIT-1:0] w_trunc_dist;
  logic                w_trunc_ok;
  logic [LNCOMMIT:0]   w_kept;
  logic [LNCOMMIT-1:0] w_trunc_tail;

  logic [NCOMMIT-1:0]  w_set_mask;
  logic [NCOMMIT-1:0]  w_clr_mask;
  logic [NCOMMIT-1:0]  w_keep_mask;

  logic [LNCOMMIT-1:0] w_head_nxt;
  logic [LNCOMMIT-1:0] w_tail_nxt;
  logic [LNCOMMIT:0]   w_busy_nxt;
  logic [NCOMMIT-1:0]  w_valid_nxt;
  logic                w_err_nxt;

  // Availability is taken before this cycle's retire, so a slot freed now
  // cannot be handed back to rename until the following cycle.
  assign w_avail       = FULL_CNT - r_busy;
  assign w_over_alloc  = ({1'b0, alloc_count} > w_avail);
  assign w_over_retire = (retire_count > r_busy);
  assign w_alloc_eff   = w_over_alloc ? '0 : alloc_count;
  assign w_retire_eff  = w_over_retire ? r_busy : retire_count;

  // The branch slot must lie strictly inside the live window; an empty
  // window therefore never accepts a truncate.
  assign w_trunc_dist = LNCOMMIT'(ring_dist(32'(r_head), 32'(trunc_addr), LNCOMMIT));
  assign w_trunc_ok   = ({1'b0, w_trunc_dist} < r_busy);
  assign w_kept       = {1'b0, w_trunc_dist} + (LNCOMMIT+1)'(1);
  assign w_trunc_tail = trunc_addr + IDX_ONE;

  ring_mask #(
    .NCOMMIT  (NCOMMIT),
    .LNCOMMIT (LNCOMMIT)
  ) u_set_mask (
    .start (r_tail),
    .count ({1'b0, w_alloc_eff}),
    .mask  (w_set_mask)
  );

  ring_mask #(
    .NCOMMIT  (NCOMMIT),
    .LNCOMMIT (LNCOMMIT)
  ) u_clr_mask (
    .start (r_head),
    .count (w_retire_eff),
    .mask  (w_clr_mask)
  );

  ring_mask #(
    .NCOMMIT  (NCOMMIT),
    .LNCOMMIT (LNCOMMIT)
  ) u_keep_mask (
    .start (r_head),
    .count (w_kept),
    .mask  (w_keep_mask)
  );

  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_busy_nxt  = r_busy;
    w_valid_nxt = r_slot_valid;
    w_err_nxt   = r_alloc_err;

    if (kill_all || (trunc_enable && !w_trunc_ok)) begin
      // Trap, or a truncate that points outside the window: drop everything
      // but leave head where it is so the ring position is preserved.
      w_tail_nxt  = r_head;
      w_busy_nxt  = '0;
      w_valid_nxt = '0;
      if (!kill_all) begin
        w_err_nxt = 1'b1;
      end
    end else if (trunc_enable) begin
      // Rename is reloading after the mispredict, so alloc_count is ignored.
      w_tail_nxt = w_trunc_tail;
      if (w_over_retire) begin
        w_err_nxt = 1'b1;
      end
      if (w_retire_eff >= w_kept) begin
        w_head_nxt  = w_trunc_tail;
        w_busy_nxt  = '0;
        w_valid_nxt = '0;
      end else begin
        w_head_nxt  = r_head + w_retire_eff[LNCOMMIT-1:0];
        w_busy_nxt  = w_kept - w_retire_eff;
        w_valid_nxt = r_slot_valid & w_keep_mask & ~w_clr_mask;
      end
    end else begin
      if (w_over_alloc || w_over_retire) begin
        w_err_nxt = 1'b1;
      end
      // Set and clear masks never overlap: alloc covers free slots only.
      w_tail_nxt  = r_tail + w_alloc_eff;
      w_head_nxt  = r_head + w_retire_eff[LNCOMMIT-1:0];
      w_busy_nxt  = r_busy + {1'b0, w_alloc_eff} - w_retire_eff;
      w_valid_nxt = (r_slot_valid | w_set_mask) & ~w_clr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_busy       <= '0;
      r_slot_valid <= '0;
      r_alloc_err  <= 1'b0;
    end else begin
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_busy       <= w_busy_nxt;
      r_slot_valid <= w_valid_nxt;
      r_alloc_err  <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registers and trivial decodes only
  // --------------------------------------------------------------------------
  assign next_start        = r_tail;
  assign current_start     = r_head;
  assign current_end       = r_tail - IDX_ONE;
  assign current_available = FULL_CNT - r_busy;
  assign slot_valid        = r_slot_valid;
  assign empty             = (r_busy == '0);
  assign full              = (r_busy == FULL_CNT);
  assign alloc_err         = r_alloc_err;

  // --------------------------------------------------------------------------
  // Window invariants
  // --------------------------------------------------------------------------
  a_popcount : assert property (@(posedge clk) disable iff (reset)
    32'($countones(r_slot_valid)) == 32'(r_busy));

  a_ring_span : assert property (@(posedge clk) disable iff (reset)
    ring_dist(32'(r_head), 32'(r_tail), LNCOMMIT) == 32'(r_busy[LNCOMMIT-1:0]));

endmodule
`default_nettype wire

// File: tb/tb_commit_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_commit_alloc                                                          |
// | Self-checking bench for commit_alloc: directed scenarios with constant   |
// | expectations followed by randomized traffic compared against a queue-    |
// | based model of the live commit window (oldest slot at the front).        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_commit_alloc;
  import commit_pkg::*;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  alloc_count;
  logic [5:0]  retire_count;
  logic        trunc_enable;
  logic [4:0]  trunc_addr;
  logic        kill_all;
  logic [4:0]  next_start;
  logic [4:0]  current_start;
  logic [4:0]  current_end;
  logic [5:0]  current_available;
  logic [31:0] slot_valid;
  logic        empty;
  logic        full;
  logic        alloc_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: head pointer plus the ordered list of live slot ids.
  int m_head = 0;
  int q[$];
  bit m_err = 1'b0;

  commit_alloc #(
    .NCOMMIT  (32),
    .LNCOMMIT (5),
    .NDEC     (4),
    .HART     (0)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .alloc_count       (alloc_count),
    .retire_count      (retire_count),
    .trunc_enable      (trunc_enable),
    .trunc_addr        (trunc_addr),
    .kill_all          (kill_all),
    .next_start        (next_start),
    .current_start     (current_start),
    .current_end       (current_end),
    .current_available (current_available),
    .slot_valid        (slot_valid),
    .empty             (empty),
    .full              (full),
    .alloc_err         (alloc_err)
  );

  always #5 clk = ~clk;

  function automatic int m_tail();
    return (m_head + q.size()) % N;
  endfunction

  function automatic logic [31:0] m_valid();
    logic [31:0] v;
    v = '0;
    foreach (q[i]) v[q[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_apply(input bit rst, input int a, input int r,
                             input bit te, input int ta, input bit k);
    int avail;
    int idx;
    int t0;
    if (rst) begin
      m_head = 0;
      q.delete();
      m_err = 1'b0;
      return;
    end
    avail = N - q.size();
    if (k) begin
      q.delete();
    end else if (te) begin
      idx = -1;
      foreach (q[i]) if (q[i] == ta) idx = i;
      if (idx < 0) begin
        m_err = 1'b1;
        q.delete();
      end else begin
        if (r > q.size()) begin
          m_err = 1'b1;
          r = q.size();
        end
        while (q.size() > idx + 1) void'(q.pop_back());
        for (int j = 0; j < r && q.size() > 0; j++) void'(q.pop_front());
        m_head = (q.size() > 0) ? q[0] : (ta + 1) % N;
      end
    end else begin
      t0 = m_tail();
      if (a > avail) begin
        m_err = 1'b1;
        a = 0;
      end
      if (r > q.size()) begin
        m_err = 1'b1;
        r = q.size();
      end
      for (int j = 0; j < a; j++) q.push_back((t0 + j) % N);
      for (int j = 0; j < r; j++) void'(q.pop_front());
      m_head = (m_head + r) % N;
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, the model is
  // advanced on the rising edge and outputs are stable 1 ns later.
  task automatic step(input bit rst, input int a, input int r,
                      input bit te, input int ta, input bit k);
    @(negedge clk);
    reset        = rst;
    alloc_count  = 5'(a);
    retire_count = 6'(r);
    trunc_enable = te;
    trunc_addr   = 5'(ta);
    kill_all     = k;
    @(posedge clk);
    model_apply(rst, a, r, te, ta, k);
    #1;
    reset        = 1'b0;
    alloc_count  = '0;
    retire_count = '0;
    trunc_enable = 1'b0;
    trunc_addr   = '0;
    kill_all     = 1'b0;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (next_start !== 5'd0 || current_start !== 5'd0) begin
      n_err++;
      $display("FAIL reset_ptrs: got next_start=%0d current_start=%0d, expected 0/0", next_start, current_start);
    end
    n_vec++;
    if (current_available !== 6'd32 || empty !== 1'b1 || full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got avail=%0d empty=%b full=%b, expected 32/1/0", current_available, empty, full);
    end
    n_vec++;
    if (slot_valid !== 32'h0 || alloc_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got slot_valid=%h alloc_err=%b, expected 0/0", slot_valid, alloc_err);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(0, 8, 0, 0, 0, 0);
      n_vec++;
      if (next_start !== 5'((8 * i) % 32)) begin
        n_err++;
        $display("FAIL fill_next_start[%0d]: got %0d expected %0d", i, next_start, (8 * i) % 32);
      end
    end
    n_vec++;
    if (full !== 1'b1 || current_available !== 6'd0 || slot_valid !== 32'hFFFF_FFFF || current_end !== 5'd31) begin
      n_err++;
      $display("FAIL fill_full: got full=%b avail=%0d valid=%h end=%0d, expected 1/0/ffffffff/31", full, current_available, slot_valid, current_end);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(0, 8, 0, 0, 0, 0);
    step(0, 8, 0, 0, 0, 0);
    step(0, 8, 0, 0, 0, 0);
    step(0, 4, 0, 0, 0, 0);
    step(0, 0, 28, 0, 0, 0);
    n_vec++;
    if (current_start !== 5'd28 || next_start !== 5'd28 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_setup: got head=%0d tail=%0d empty=%b, expected 28/28/1", current_start, next_start, empty);
    end
    step(0, 6, 0, 0, 0, 0);
    n_vec++;
    if (slot_valid !== 32'hF000_0003 || next_start !== 5'd2 || current_end !== 5'd1) begin
      n_err++;
      $display("FAIL wrap_alloc: got valid=%h next=%0d end=%0d, expected f0000003/2/1", slot_valid, next_start, current_end);
    end
  endtask

  task automatic test_trunc();
    do_reset();
    step(0, 8, 0, 0, 0, 0);
    step(0, 8, 0, 0, 0, 0);
    step(0, 4, 0, 0, 0, 0);
    step(0, 0, 4, 0, 0, 0);
    step(0, 5, 2, 1, 9, 0);
    n_vec++;
    if (current_start !== 5'd6 || next_start !== 5'd10 || current_available !== 6'd28) begin
      n_err++;
      $display("FAIL trunc_ptrs: got head=%0d tail=%0d avail=%0d, expected 6/10/28", current_start, next_start, current_available);
    end
    n_vec++;
    if (slot_valid !== 32'h0000_03C0 || alloc_err !== 1'b0) begin
      n_err++;
      $display("FAIL trunc_valid: got valid=%h err=%b, expected 000003c0/0", slot_valid, alloc_err);
    end
    // Retire swallows everything kept: window collapses to just past the branch.
    step(0, 0, 3, 1, 7, 0);
    n_vec++;
    if (current_start !== 5'd8 || next_start !== 5'd8 || empty !== 1'b1 || alloc_err !== 1'b0) begin
      n_err++;
      $display("FAIL trunc_drain: got head=%0d tail=%0d empty=%b err=%b, expected 8/8/1/0", current_start, next_start, empty, alloc_err);
    end
  endtask

  task automatic test_kill();
    do_reset();
    step(0, 8, 0, 0, 0, 0);
    step(0, 8, 0, 0, 0, 0);
    step(0, 6, 0, 0, 0, 0);
    step(0, 0, 10, 0, 0, 0);
    step(0, 3, 1, 0, 0, 1);
    n_vec++;
    if (current_start !== 5'd10 || next_start !== 5'd10 || current_available !== 6'd32) begin
      n_err++;
      $display("FAIL kill_ptrs: got head=%0d tail=%0d avail=%0d, expected 10/10/32", current_start, next_start, current_available);
    end
    n_vec++;
    if (slot_valid !== 32'h0 || alloc_err !== 1'b0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL kill_state: got valid=%h err=%b empty=%b, expected 0/0/1", slot_valid, alloc_err, empty);
    end
  endtask

  task automatic test_errors();
    do_reset();
    step(0, 8, 0, 0, 0, 0);
    step(0, 8, 0, 0, 0, 0);
    step(0, 8, 0, 0, 0, 0);
    step(0, 6, 0, 0, 0, 0);
    step(0, 4, 0, 0, 0, 0);
    n_vec++;
    if (next_start !== 5'd30 || current_available !== 6'd2 || alloc_err !== 1'b1 || slot_valid !== 32'h3FFF_FFFF) begin
      n_err++;
      $display("FAIL over_alloc: got tail=%0d avail=%0d err=%b valid=%h, expected 30/2/1/3fffffff", next_start, current_available, alloc_err, slot_valid);
    end
    step(0, 0, 25, 0, 0, 0);
    step(0, 0, 40, 0, 0, 0);
    n_vec++;
    if (empty !== 1'b1 || current_start !== 5'd30 || current_available !== 6'd32 || alloc_err !== 1'b1) begin
      n_err++;
      $display("FAIL over_retire: got empty=%b head=%0d avail=%0d err=%b, expected 1/30/32/1", empty, current_start, current_available, alloc_err);
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (alloc_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: got alloc_err=%b expected 1", alloc_err);
    end
    // Window 30,31,0,1 then a truncate at slot 5, which is not live.
    step(0, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0);
    n_vec++;
    if (empty !== 1'b1 || next_start !== 5'd30 || current_start !== 5'd30 || slot_valid !== 32'h0) begin
      n_err++;
      $display("FAIL trunc_bad: got empty=%b tail=%0d head=%0d valid=%h, expected 1/30/30/0", empty, next_start, current_start, slot_valid);
    end
    do_reset();
    n_vec++;
    if (alloc_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: got alloc_err=%b expected 0", alloc_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 8, 0, 0, 0, 0);
    // Retired slots are not reusable in the same cycle, so this alloc overflows.
    step(0, 4, 4, 0, 0, 0);
    n_vec++;
    if (current_start !== 5'd4 || next_start !== 5'd0 || current_available !== 6'd4 || alloc_err !== 1'b1) begin
      n_err++;
      $display("FAIL same_cycle_reuse: got head=%0d tail=%0d avail=%0d err=%b, expected 4/0/4/1", current_start, next_start, current_available, alloc_err);
    end
    step(0, 4, 2, 0, 0, 0);
    n_vec++;
    if (current_start !== 5'd6 || next_start !== 5'd4 || current_available !== 6'd2 || slot_valid !== 32'hFFFF_FFCF) begin
      n_err++;
      $display("FAIL alloc_retire: got head=%0d tail=%0d avail=%0d valid=%h, expected 6/4/2/ffffffcf", current_start, next_start, current_available, slot_valid);
    end
  endtask

  task automatic test_random();
    int sel;
    int a;
    int r;
    int ta;
    int sz;
    bit te;
    bit k;
    bit rs;
    commit_idx_t exp_end;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      sel = $urandom_range(0, 99);
      sz  = q.size();
      a = 0; r = 0; ta = 0; te = 1'b0; k = 1'b0; rs = 1'b0;
      if (sel < 2) begin
        rs = 1'b1;
        a  = $urandom_range(0, 8);
      end else if (sel < 5) begin
        k = 1'b1;
        a = $urandom_range(0, 8);
        r = $urandom_range(0, 8);
      end else if (sel < 13 && sz > 0) begin
        te = 1'b1;
        ta = q[$urandom_range(0, sz - 1)];
        r  = $urandom_range(0, sz);
        a  = $urandom_range(0, 8);
      end else if (sel < 15) begin
        te = 1'b1;
        ta = $urandom_range(0, 31);
        r  = $urandom_range(0, (sz < 4) ? sz : sz / 3);
      end else begin
        a = $urandom_range(0, MAX_ALLOC);
        if (a > N - sz) a = N - sz;
        r = $urandom_range(0, (sz < 4) ? sz : sz / 3);
        if (sel >= 98) a = $urandom_range(0, 31);
        if (sel == 96 || sel == 97) r = $urandom_range(0, 40);
      end
      step(rs, a, r, te, ta, k);
      exp_end = commit_idx_t'((m_tail() + N - 1) % N);
      n_vec++;
      if (next_start !== 5'(m_tail()) || current_start !== 5'(m_head) ||
          current_available !== 6'(N - q.size()) || slot_valid !== m_valid() ||
          empty !== (q.size() == 0) || full !== (q.size() == N) || alloc_err !== m_err ||
          (q.size() > 0 && current_end !== exp_end)) begin
        n_err++;
        $display("FAIL rand[%0d]: tail=%0d/%0d head=%0d/%0d avail=%0d/%0d valid=%h/%h end=%0d/%0d empty=%b full=%b err=%b/%b (got/expected)",
                 c, next_start, m_tail(), current_start, m_head, current_available, N - q.size(),
                 slot_valid, m_valid(), current_end, exp_end, empty, full, alloc_err, m_err);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    alloc_count  = '0;
    retire_count = '0;
    trunc_enable = 1'b0;
    trunc_addr   = '0;
    kill_all     = 1'b0;
    test_reset();
    test_fill();
    test_wrap();
    test_trunc();
    test_kill();
    test_errors();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/commit_alloc.md
Name: commit_alloc

Overview:
- Commit-slot allocator feeding the rename stage.
- Owns the circular window of NCOMMIT commit stations: head is the oldest live slot, tail is the next free slot.
- Drives next_start and current_available to rename. Consumes the per-cycle allocation count from rename control and the retire count from commit.
- Truncates the window on branch mispredict and empties it on trap.

Parameters:
NCOMMIT, 32, number of commit stations (power of 2: 16/32/64)
LNCOMMIT, 5, log2(NCOMMIT)
NDEC, 4, decode width; max allocation per cycle is 2*NDEC
HART, 0, hart id (informational, no logic)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
alloc_count  in  LNCOMMIT  slots renamed this cycle (0..2*NDEC), from rename control count_out
retire_count  in  LNCOMMIT+1  oldest slots retired this cycle (0..NCOMMIT)
trunc_enable  in  1  mispredict: keep slots head..trunc_addr inclusive, free the rest
trunc_addr  in  LNCOMMIT  last surviving slot (the branch itself)
kill_all  in  1  trap/interrupt: free every slot
next_start  out  LNCOMMIT  tail; rename instance k uses next_start+k
current_start  out  LNCOMMIT  head
current_end  out  LNCOMMIT  last live slot (tail-1), undefined when empty
current_available  out  LNCOMMIT+1  free slots, NCOMMIT-busy
slot_valid  out  NCOMMIT  1 = station live
empty  out  1  busy==0
full  out  1  busy==NCOMMIT
alloc_err  out  1  sticky: over-allocation or over-retire seen

Behaviour:
- State: head, tail (LNCOMMIT bits, mod NCOMMIT), busy (LNCOMMIT+1 bits), slot_valid, alloc_err.
- Reset: head=tail=0, busy=0, slot_valid=0, alloc_err=0. Outputs then read: next_start=0, current_start=0, current_available=NCOMMIT, empty=1, full=0.
- All outputs come directly from registers or from a trivial decode of registers. No combinational path from inputs to outputs.
- Updates take effect one clock later. Rename sees the new next_start in the cycle after an allocation.
- Priority per cycle, highest first:
  - reset
  - kill_all: head=tail=0? No — head unchanged, tail=head, busy=0, slot_valid=0. retire_count and alloc_count are ignored.
  - trunc_enable:
    - kept = ((trunc_addr-head) mod NCOMMIT)+1.
    - tail = trunc_addr+1, busy = kept-retire_count.
    - slot_valid is cleared outside head..trunc_addr, and for the retired slots.
    - alloc_count is ignored (rename is reloading).
    - If retire_count>=kept, busy=0 and head=tail.
  - normal:
    - busy += alloc_count-retire_count.
    - tail += alloc_count, head += retire_count.
    - slot_valid: set alloc_count bits from the old tail and clear retire_count bits from the old head. Both are wrap-aware.
- Simultaneous alloc and retire are both applied in the same cycle. A slot freed by retire is not reusable until the next cycle: current_available is computed before the retire.
- Over-allocation (alloc_count > current_available):
  - alloc_count is ignored.
  - alloc_err is set.
  - This cannot occur legally because rename control zeroes count when it would exceed current_available.
- Over-retire (retire_count > busy): clamp to busy and set alloc_err.
- trunc_addr outside the live window is illegal: set alloc_err and treat as kill_all.
- Wrap-around: all pointer arithmetic is mod NCOMMIT. Ring masks handle start+count crossing NCOMMIT-1 to 0.
- Full: tail==head with busy==NCOMMIT. Empty: tail==head with busy==0. busy disambiguates the two.
- Reset mid-operation takes effect in the next clock regardless of other inputs.
- Invariants, checked by assertion:
  - popcount(slot_valid)==busy.
  - (tail-head) mod NCOMMIT == busy mod NCOMMIT.

Decomposition:
- Package commit_pkg:
  - typedef commit_idx_t [LNCOMMIT-1:0].
  - typedef commit_cnt_t [LNCOMMIT:0].
  - Function ring_dist(a,b).
  - Constant MAX_ALLOC=2*NDEC.
- Sub-module ring_mask:
  - Inputs start, count. Output NCOMMIT-bit wrap-aware contiguous mask.
  - Instantiated three times: alloc set mask, retire clear mask, truncate keep mask.

Test Plan:
- Reset, then idle 3 cycles → next_start=0, current_available=32, empty=1, slot_valid=0.
- alloc_count=8 for 4 cycles → next_start=0,8,16,24 then 0; full=1; current_available=0; slot_valid all ones.
- head=28, tail=28 (empty), alloc_count=6 → slot_valid bits 28-31 and 0-1 set; next_start=2; current_end=1.
- Window head=4, tail=20; trunc_enable, trunc_addr=9, retire_count=2, alloc_count=5 → head=6, tail=10, busy=4, slot_valid bits 6-9 only, next_start=10.
- Window head=10, busy=12; kill_all with alloc_count=3, retire_count=1 → busy=0, tail=head=10, current_available=32, alloc_err=0.
- current_available=2, alloc_count=4 → state unchanged, alloc_err=1 and stays 1 until reset; retire_count=40 with busy=5 → busy=0, alloc_err=1.
